// File: rtl/swatt_scheduler_pkg.sv
// Shared definitions for the SW-Att secure-ROM scheduler.
//   - SMEM address map and the reset-handler PC that releases a fault
//   - scheduler state encoding
//   - address-window helpers used by the FSM
package swatt_scheduler_pkg;

    localparam logic [15:0] SMEM_BASE      = 16'hE000;
    localparam logic [15:0] SMEM_SIZE      = 16'h1000;
    localparam logic [15:0] LAST_SMEM_ADDR = SMEM_BASE + SMEM_SIZE - 16'd2;
    localparam logic [15:0] RESET_HANDLER  = 16'hFFFE;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WAIT_ENTRY = 3'd1,
        ST_RUN        = 3'd2,
        ST_EXIT       = 3'd3,
        ST_FAULT      = 3'd4
    } sched_state_t;

    function automatic logic f_in_smem(input logic [15:0] pc);
        return (pc >= SMEM_BASE) && (pc <= LAST_SMEM_ADDR);
    endfunction

    // Strictly inside SMEM: neither the entry nor the exit address.
    function automatic logic f_mid_smem(input logic [15:0] pc);
        return (pc > SMEM_BASE) && (pc < LAST_SMEM_ADDR);
    endfunction

endpackage

// File: rtl/swatt_scheduler_if.sv
// Bus bundle between the CPU-side monitor/requesters and the scheduler.
//   pc, req                   : driven by the system (master)
//   gnt, irq_mask, busy       : slot status (slave)
//   done, abort, done_id      : per-slot completion report (slave)
//   reset_req                 : sticky system reset request (slave)
interface swatt_scheduler_if #(
    parameter int NREQ = 2
);
    localparam int ID_W = $clog2(NREQ);

    logic [15:0]     pc;
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            irq_mask;
    logic            busy;
    logic            done;
    logic            abort;
    logic [ID_W-1:0] done_id;
    logic            reset_req;

    modport master (
        output pc, req,
        input  gnt, irq_mask, busy, done, abort, done_id, reset_req
    );

    modport slave (
        input  pc, req,
        output gnt, irq_mask, busy, done, abort, done_id, reset_req
    );
endinterface

// File: rtl/swatt_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   i_req   : request vector
//   i_ptr   : index of the last served requester; search starts just after it
//   o_win   : index of the winning requester
//   o_valid : at least one request present
module swatt_scheduler_rr_arbiter #(
    parameter int NREQ  = 2,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [PTR_W-1:0] o_win,
    output logic             o_valid
);
    int               idx;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_win   = '0;
        o_valid = 1'b0;
        idx     = 0;
        w_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(i_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            w_idx = PTR_W'(idx);
            if (!o_valid && i_req[w_idx]) begin
                o_win   = w_idx;
                o_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/swatt_scheduler.sv
// SW-Att slot scheduler: grants exclusive SMEM use to one requester, masks
// interrupts for the slot, follows the PC through entry/body/exit and raises
// a sticky reset request on any out-of-sequence SMEM access or watchdog expiry.
//   clk, reset_n : system clock, async active-low reset
//   bus (slave)  : pc/req in; gnt, irq_mask, busy, done, abort, done_id, reset_req out
//
// state      | meaning
// IDLE       | no slot; arbitrate, any SMEM access is a fault
// WAIT_ENTRY | slot granted, waiting for pc == SMEM_BASE
// RUN        | executing SMEM body, run watchdog active
// EXIT       | at LAST_SMEM_ADDR, leaving SMEM completes the slot
// FAULT      | reset_req held until the CPU reaches the reset handler
module swatt_scheduler
    import swatt_scheduler_pkg::*;
#(
    parameter int                   NREQ          = 2,
    parameter int                   ENTRY_TIMEOUT = 16,
    parameter int                   RUN_CNT_W     = 24,
    parameter logic [RUN_CNT_W-1:0] RUN_MAX       = 24'hFFFFF0
) (
    input  logic              clk,
    input  logic              reset_n,
    swatt_scheduler_if.slave  bus
);
    localparam int PTR_W = $clog2(NREQ);
    localparam int ENT_W = $clog2(ENTRY_TIMEOUT + 1);

    sched_state_t         r_state, w_state_nxt;
    logic [NREQ-1:0]      r_gnt, w_gnt_nxt;
    logic                 r_irq_mask, w_irq_mask_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_done, w_done_nxt;
    logic                 r_abort, w_abort_nxt;
    logic [PTR_W-1:0]     r_done_id, w_done_id_nxt;
    logic                 r_reset_req, w_reset_req_nxt;
    logic [ENT_W-1:0]     r_ent_cnt, w_ent_cnt_nxt;
    logic [RUN_CNT_W-1:0] r_run_cnt, w_run_cnt_nxt;
    logic [PTR_W-1:0]     r_rr_ptr, w_rr_ptr_nxt;
    logic [PTR_W-1:0]     r_owner, w_owner_nxt;

    logic [PTR_W-1:0]     w_win;
    logic                 w_valid;
    logic                 w_in_smem;
    logic                 w_slot_now;
    logic                 w_slot_nxt;
    logic                 w_grant;

    swatt_scheduler_rr_arbiter #(.NREQ(NREQ), .PTR_W(PTR_W)) u_arb (
        .i_req   (bus.req),
        .i_ptr   (r_rr_ptr),
        .o_win   (w_win),
        .o_valid (w_valid)
    );

    assign w_in_smem = f_in_smem(bus.pc);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_gnt       <= '0;
            r_irq_mask  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_abort     <= 1'b0;
            r_done_id   <= '0;
            r_reset_req <= 1'b0;
            r_ent_cnt   <= '0;
            r_run_cnt   <= '0;
            r_rr_ptr    <= PTR_W'(NREQ - 1);
            r_owner     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_irq_mask  <= w_irq_mask_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_abort     <= w_abort_nxt;
            r_done_id   <= w_done_id_nxt;
            r_reset_req <= w_reset_req_nxt;
            r_ent_cnt   <= w_ent_cnt_nxt;
            r_run_cnt   <= w_run_cnt_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_owner     <= w_owner_nxt;
        end
    end

    // In RUN a PC leaving SMEM is checked before the watchdog, and the
    // watchdog before a legal arrival at the exit address.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_in_smem)    w_state_nxt = ST_FAULT;
                else if (w_valid) w_state_nxt = ST_WAIT_ENTRY;
            end
            ST_WAIT_ENTRY: begin
                if (bus.pc == SMEM_BASE) w_state_nxt = ST_RUN;
                else if (w_in_smem)      w_state_nxt = ST_FAULT;
                else if (!bus.req[r_owner] || (r_ent_cnt == ENT_W'(ENTRY_TIMEOUT - 1)))
                    w_state_nxt = ST_IDLE;
            end
            ST_RUN: begin
                if (!w_in_smem)                   w_state_nxt = ST_FAULT;
                else if (r_run_cnt == RUN_MAX)    w_state_nxt = ST_FAULT;
                else if (bus.pc == LAST_SMEM_ADDR) w_state_nxt = ST_EXIT;
            end
            ST_EXIT: begin
                if (bus.pc == LAST_SMEM_ADDR) w_state_nxt = ST_EXIT;
                else if (!w_in_smem)          w_state_nxt = ST_IDLE;
                else                          w_state_nxt = ST_FAULT;
            end
            ST_FAULT: begin
                if (bus.pc == RESET_HANDLER) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are derived from the (current, next) state pair so every
    // registered output changes on the same edge as the state.
    always_comb begin
        w_slot_now = (r_state == ST_WAIT_ENTRY) || (r_state == ST_RUN) || (r_state == ST_EXIT);
        w_slot_nxt = (w_state_nxt == ST_WAIT_ENTRY) || (w_state_nxt == ST_RUN) ||
                     (w_state_nxt == ST_EXIT);
        w_grant    = (r_state == ST_IDLE) && (w_state_nxt == ST_WAIT_ENTRY);

        w_done_nxt  = (r_state == ST_EXIT) && (w_state_nxt == ST_IDLE);
        w_abort_nxt = ((r_state == ST_WAIT_ENTRY) && (w_state_nxt == ST_IDLE)) ||
                      (w_slot_now && (w_state_nxt == ST_FAULT));
        w_done_id_nxt = (w_done_nxt || w_abort_nxt) ? r_owner : '0;

        w_gnt_nxt = '0;
        if (w_grant)         w_gnt_nxt = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
        else if (w_slot_nxt) w_gnt_nxt = r_gnt;
        w_irq_mask_nxt  = w_slot_nxt;
        w_busy_nxt      = w_slot_nxt;
        w_reset_req_nxt = (w_state_nxt == ST_FAULT);

        w_owner_nxt = w_grant ? w_win : r_owner;
        // rr_ptr only advances on a slot that ends normally (done or abort to IDLE).
        w_rr_ptr_nxt = (w_slot_now && (w_state_nxt == ST_IDLE)) ? r_owner : r_rr_ptr;

        w_ent_cnt_nxt = r_ent_cnt;
        if (w_grant) w_ent_cnt_nxt = '0;
        else if ((r_state == ST_WAIT_ENTRY) && (w_state_nxt == ST_WAIT_ENTRY))
            w_ent_cnt_nxt = r_ent_cnt + 1'b1;

        w_run_cnt_nxt = r_run_cnt;
        if ((r_state == ST_WAIT_ENTRY) && (w_state_nxt == ST_RUN))
            w_run_cnt_nxt = '0;
        else if ((r_state == ST_RUN) && (r_run_cnt != RUN_MAX))
            w_run_cnt_nxt = r_run_cnt + 1'b1;
    end

    assign bus.gnt       = r_gnt;
    assign bus.irq_mask  = r_irq_mask;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.abort     = r_abort;
    assign bus.done_id   = r_done_id;
    assign bus.reset_req = r_reset_req;

endmodule

// File: tb/tb_swatt_scheduler.sv
module tb_swatt_scheduler;
    localparam int          NREQ     = 2;
    localparam int          TIMEOUT  = 16;
    localparam int          RUN_LIM  = 40;
    localparam logic [15:0] BASE     = 16'hE000;
    localparam logic [15:0] LAST     = 16'hEFFE;
    localparam logic [15:0] HANDLER  = 16'hFFFE;

    typedef struct {
        logic [NREQ-1:0] gnt;
        logic            irq;
        logic            busy;
        logic            done;
        logic            abort;
        int              id;
        logic            rst;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    swatt_scheduler_if #(.NREQ(NREQ)) bus();

    swatt_scheduler #(
        .NREQ(NREQ), .ENTRY_TIMEOUT(TIMEOUT), .RUN_CNT_W(24), .RUN_MAX(24'(RUN_LIM))
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int checks = 0;
    int failures = 0;
    exp_t expq[$];

    // Reference model: slot ownership plus progress flags.
    int m_owner;     // -1 when no slot is open
    int m_last;      // last requester served
    bit m_entered, m_at_exit, m_fault;
    int m_wait, m_run;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit in_smem(input logic [15:0] pc);
        return pc >= BASE && pc <= LAST;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = NREQ - 1; m_entered = 0; m_at_exit = 0;
        m_fault = 0; m_wait = 0; m_run = 0;
    endtask

    task automatic model_step(input logic [15:0] pc, input logic [NREQ-1:0] req, output exp_t e);
        e.done = 0; e.abort = 0; e.id = 0;
        if (m_fault) begin
            if (pc == HANDLER) m_fault = 0;
        end else if (m_owner < 0) begin
            if (in_smem(pc)) m_fault = 1;
            else if (req != 0) begin
                for (int k = 1; k <= NREQ; k++) begin
                    int i;
                    i = (m_last + k) % NREQ;
                    if (m_owner < 0 && req[i]) m_owner = i;
                end
                m_entered = 0; m_at_exit = 0; m_wait = 0;
            end
        end else begin
            bit to_fault, to_idle;
            to_fault = 0; to_idle = 0;
            if (!m_entered) begin
                if (pc == BASE) begin m_entered = 1; m_run = 0; end
                else if (in_smem(pc)) to_fault = 1;
                else if (!req[m_owner] || m_wait == TIMEOUT - 1) begin to_idle = 1; e.abort = 1; end
                else m_wait++;
            end else if (!m_at_exit) begin
                if (!in_smem(pc) || m_run == RUN_LIM) to_fault = 1;
                else if (pc == LAST) m_at_exit = 1;
                else m_run++;
            end else begin
                if (pc == LAST) ;
                else if (!in_smem(pc)) begin to_idle = 1; e.done = 1; end
                else to_fault = 1;
            end
            if (to_fault) begin
                e.abort = 1; e.id = m_owner; m_owner = -1; m_fault = 1;
            end else if (to_idle) begin
                e.id = m_owner; m_last = m_owner; m_owner = -1;
            end
        end
        e.gnt  = (m_owner >= 0) ? NREQ'(1) << m_owner : '0;
        e.irq  = (m_owner >= 0);
        e.busy = (m_owner >= 0);
        e.rst  = m_fault;
    endtask

    task automatic step(input logic [15:0] pc, input logic [NREQ-1:0] req);
        exp_t e;
        @(negedge clk);
        bus.pc = pc; bus.req = req;
        model_step(pc, req, e);
        expq.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"},   32'(bus.gnt), 0);
        check({tag, "_irq"},   32'(bus.irq_mask), 0);
        check({tag, "_busy"},  32'(bus.busy), 0);
        check({tag, "_done"},  32'(bus.done), 0);
        check({tag, "_abort"}, 32'(bus.abort), 0);
        check({tag, "_rreq"},  32'(bus.reset_req), 0);
        check({tag, "_id"},    32'(bus.done_id), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0; bus.pc = 16'h4000; bus.req = '0;
        model_reset();
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic legal_slot(input logic [NREQ-1:0] req);
        step(16'h4000, req); step(BASE, req); step(16'hE010, req);
        step(LAST, req); step(16'h4000, req);
    endtask

    // Monitor: one expectation per clocked cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (reset_n && expq.size() > 0) begin
                e = expq.pop_front();
                check("gnt",   32'(bus.gnt), 32'(e.gnt));
                check("irq",   32'(bus.irq_mask), 32'(e.irq));
                check("busy",  32'(bus.busy), 32'(e.busy));
                check("done",  32'(bus.done), 32'(e.done));
                check("abort", 32'(bus.abort), 32'(e.abort));
                check("rreq",  32'(bus.reset_req), 32'(e.rst));
                if (e.done || e.abort) check("done_id", 32'(bus.done_id), 32'(e.id));
            end
        end
    end

    initial begin
        logic [15:0]     pc;
        logic [NREQ-1:0] rq;
        bus.pc = 16'h4000; bus.req = '0;
        model_reset();
        #1 check_all_zero("por");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // normal slot, then fairness over two back-to-back slots
        legal_slot(2'b01); step(16'h4000, 2'b00);
        do_reset();
        legal_slot(2'b11); legal_slot(2'b11); step(16'h4000, 2'b00);

        // entry timeout
        do_reset();
        repeat (18) step(16'h4000, 2'b01);
        step(16'h4000, 2'b00);

        // bad entry, fault held until the reset handler
        do_reset();
        step(16'h4000, 2'b01); step(16'hE100, 2'b01);
        repeat (3) step(16'h1234, 2'b00);
        step(HANDLER, 2'b00); step(16'h4000, 2'b00);

        // mid-run escape, then back-jump from exit
        step(16'h4000, 2'b01); step(BASE, 2'b01); step(16'hE020, 2'b01); step(16'h5000, 2'b01);
        step(HANDLER, 2'b00);
        step(16'h4000, 2'b01); step(BASE, 2'b01); step(LAST, 2'b01); step(BASE, 2'b01);
        step(HANDLER, 2'b00);

        // req drop in WAIT aborts, req drop in RUN is ignored
        step(16'h4000, 2'b10); step(16'h4000, 2'b00);
        step(16'h4000, 2'b10); step(BASE, 2'b00); step(LAST, 2'b00); step(16'h4000, 2'b00);

        // run watchdog
        step(16'h4000, 2'b01); step(BASE, 2'b01);
        repeat (RUN_LIM + 2) step(16'hE010, 2'b01);
        step(HANDLER, 2'b00);

        // unscheduled entry, then async reset mid-RUN
        step(BASE, 2'b00); step(HANDLER, 2'b00);
        step(16'h4000, 2'b01); step(BASE, 2'b01);
        @(posedge clk); #3;
        reset_n = 1'b0;
        #1 check_all_zero("async");
        model_reset();
        @(negedge clk); bus.pc = 16'h4000; bus.req = '0;
        @(negedge clk); reset_n = 1'b1;

        // random phase: software-like PC walk steered by the model's view
        rq = '0;
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 11) == 0) rq[$urandom_range(0, NREQ - 1)] ^= 1'b1;
            pc = 16'($urandom_range(0, 16'hDFFF));
            if (m_fault) begin
                if ($urandom_range(0, 3) == 0) pc = HANDLER;
            end else if (m_owner < 0) begin
                if ($urandom_range(0, 59) == 0) pc = BASE;
            end else if (!m_entered) begin
                if ($urandom_range(0, 3) == 0) pc = BASE;
                else if ($urandom_range(0, 39) == 0) pc = BASE + 16'($urandom_range(1, 16'h0FFD));
            end else if (!m_at_exit) begin
                if ($urandom_range(0, 2) == 0) pc = LAST;
                else if ($urandom_range(0, 49) != 0) pc = BASE + 16'($urandom_range(0, 16'h0FFD));
            end else begin
                if ($urandom_range(0, 1) == 0) pc = LAST;
                else if ($urandom_range(0, 29) == 0) pc = BASE + 16'($urandom_range(0, 16'h0FFD));
            end
            step(pc, rq);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 32'(expq.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
